// File: rtl/ksa_addsub_pipe.sv
// Pipelined Kogge-Stone add/sub with NZCV flags. Latency is PIPE_STAGES+1 cycles when not stalled.
// Backpressure: a stage advances when the stage after it is empty or advancing, so the ready chain is combinational.
module ksa_addsub_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  input  logic              i_sub,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_sum,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_n,
  output logic              o_z,
  output logic              o_c,
  output logic              o_v
);

  localparam int LEVELS = $clog2(DATA_W);
  localparam int NS     = PIPE_STAGES + 1;

  typedef struct packed {
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] gp;
    logic [DATA_W-1:0] p;
    logic              c0;
    logic              a_msb;
    logic              b_msb;
    logic [TAG_W-1:0]  tag;
  } pfx_t;

  // Pipeline register s sits after prefix boundary floor(s*LEVELS/NS); 0 means no register there.
  function automatic int stage_at(input int b);
    int s_hit;
    s_hit = 0;
    for (int s = 1; s <= PIPE_STAGES; s++)
      if ((s * LEVELS) / NS == b) s_hit = s;
    return s_hit;
  endfunction

  function automatic pfx_t combine(input pfx_t x, input int d);
    pfx_t y;
    y    = x;
    y.g  = x.g | (x.gp & (x.g << d));
    y.gp = x.gp & (x.gp << d);
    return y;
  endfunction

  logic [NS:1] vld_q;
  logic [NS:1] vin;
  logic [NS:1] rdy;
  logic [NS:1] load;

  always_comb begin : ready_chain
    logic acc;
    acc = i_ready;
    rdy = '0;
    for (int s = NS; s >= 1; s--) begin
      acc    = acc | ~vld_q[s];
      rdy[s] = acc;
    end
  end

  assign vin     = NS'({vld_q, i_valid});
  assign load    = vin & rdy;
  assign o_ready = rdy[1];
  assign o_valid = vld_q[NS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vld_q <= '0;
    else          vld_q <= (vld_q & ~rdy) | (vin & rdy);
  end

  logic [DATA_W-1:0] b_eff;
  logic              c0;
  pfx_t              pg0;

  assign b_eff = i_sub ? ~i_b : i_b;
  assign c0    = i_sub | i_cin;

  // Carry-in is absorbed into g[0]; gp[0] is cleared so no group can propagate past bit 0.
  always_comb begin
    pg0       = '0;
    pg0.p     = i_a ^ b_eff;
    pg0.g     = i_a & b_eff;
    pg0.g[0]  = (i_a[0] & b_eff[0]) | (i_a[0] & c0) | (b_eff[0] & c0);
    pg0.gp    = i_a ^ b_eff;
    pg0.gp[0] = 1'b0;
    pg0.c0    = c0;
    pg0.a_msb = i_a[DATA_W-1];
    pg0.b_msb = b_eff[DATA_W-1];
    pg0.tag   = i_tag;
  end

  pfx_t pfx_in  [0:LEVELS];
  pfx_t pfx_out [0:LEVELS];

  assign pfx_in[0] = pg0;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    assign pfx_in[k] = combine(pfx_out[k-1], 1 << (k - 1));
  end

  for (genvar b = 0; b <= LEVELS; b++) begin : g_bnd
    localparam int S = stage_at(b);
    if (S != 0) begin : g_reg
      pfx_t q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     q <= '0;
        else if (load[S]) q <= pfx_in[b];
      end
      assign pfx_out[b] = q;
    end else begin : g_wire
      assign pfx_out[b] = pfx_in[b];
    end
  end

  logic [DATA_W-1:0] sum;
  logic              ovf;

  assign sum = pfx_out[LEVELS].p ^ {pfx_out[LEVELS].g[DATA_W-2:0], pfx_out[LEVELS].c0};
  assign ovf = (pfx_out[LEVELS].a_msb == pfx_out[LEVELS].b_msb) &
               (sum[DATA_W-1] != pfx_out[LEVELS].a_msb);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum <= '0;
      o_tag <= '0;
      o_n   <= 1'b0;
      o_z   <= 1'b0;
      o_c   <= 1'b0;
      o_v   <= 1'b0;
    end else if (load[NS]) begin
      o_sum <= sum;
      o_tag <= pfx_out[LEVELS].tag;
      o_n   <= sum[DATA_W-1];
      o_z   <= (sum == '0);
      o_c   <= pfx_out[LEVELS].g[DATA_W-1];
      o_v   <= ovf;
    end
  end

endmodule
